// File: rtl/ram_single_param_if.sv
// ram_single_param_if: access bus of the single-port RAM
// master drives en/we/addr/di; slave returns data_o, valid_o (one-cycle pulse with new data)
// and ready_o (accesses accepted).
interface ram_single_param_if #(
    parameter int ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH    = 16
);
    logic                         en;
    logic [DATA_WIDTH/8-1:0]      we;
    logic [ADDRESS_WIDTH-1:0]     addr;
    logic signed [DATA_WIDTH-1:0] di;
    logic signed [DATA_WIDTH-1:0] data_o;
    logic                         valid_o;
    logic                         ready_o;
    modport master(output en, we, addr, di, input data_o, valid_o, ready_o);
    modport slave(input en, we, addr, di, output data_o, valid_o, ready_o);
endinterface

// File: rtl/ram_single_param.sv
// ram_single_param: single-port byte-writable RAM with zero-fill after reset and optional output register
// clk/rst: clock and async active-high reset; bus: en, we (per byte), addr, di in; data_o, valid_o, ready_o out.
module ram_single_param #(
    parameter int ADDRESS_WIDTH  = 7,
    parameter int DATA_WIDTH     = 16,
    parameter int DO_REG         = 0,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic               clk,
    input logic               rst,
    ram_single_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [DATA_WIDTH-1:0]    rd_word, merged, nxt, q1, q2;
    logic                     v1, v2, acc, wr, clr, load;

    assign acc     = bus.en && state == READY;
    assign wr      = acc && |bus.we;
    assign clr     = state == CLEAR && CLEAR_ON_RESET != 0;
    assign rd_word = mem[bus.addr];

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++)
            if (bus.we[i]) merged[8*i +: 8] = bus.di[8*i +: 8];
    end

    // memory has no reset: contents are only ever changed by clear or user writes
    always_ff @(posedge clk)
        if (clr) mem[cnt] <= '0;
        else if (wr) mem[bus.addr] <= merged;

    // counter parks at depth-1 instead of wrapping; READY is entered on the edge that writes the last word
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (!clr || &cnt) state <= READY;
            else cnt <= cnt + 1'b1;
        end

    // NO_CHANGE writes neither load nor pulse; other modes return old or merged word
    assign load = acc && (!wr || WRITE_MODE != 0);
    assign nxt  = wr && WRITE_MODE == 2 ? merged : rd_word;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            q1 <= '0;
            v1 <= 1'b0;
            q2 <= '0;
            v2 <= 1'b0;
        end else begin
            v1 <= load;
            if (load) q1 <= nxt;
            v2 <= v1;
            if (v1) q2 <= q1;
        end

    assign bus.data_o  = DO_REG != 0 ? q2 : q1;
    assign bus.valid_o = DO_REG != 0 ? v2 : v1;
    assign bus.ready_o = state == READY;
endmodule

// File: doc/ram_single_param.md
RAM_SINGLE_PARAM -- requirements
Module: ram_single_param

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 7, meaning address bits; depth = 2**ADDRESS_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning word width, a multiple of 8, range 8..64.
REQ-003 SHALL have parameter DO_REG, default 0, meaning extra output register; 0 gives read latency 1, 1 gives read latency 2.
REQ-004 SHALL have parameter WRITE_MODE, default 0, meaning port behaviour on write: 0 NO_CHANGE, 1 READ_FIRST, 2 WRITE_FIRST.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill of all words after reset (1) or no fill (0).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1 bit: access enable.
REQ-009 SHALL have port we, input, DATA_WIDTH/8 bits: per-byte write enable; bit i covers di[8i+7:8i].
REQ-010 SHALL have port addr, input, ADDRESS_WIDTH bits: word address.
REQ-011 SHALL have port di, input, DATA_WIDTH bits, signed: write data.
REQ-012 SHALL have port data_o, output, DATA_WIDTH bits, signed: read data.
REQ-013 SHALL have port valid_o, output, 1 bit: one-cycle pulse, asserted in the cycle data_o carries new data.
REQ-014 SHALL have port ready_o, output, 1 bit: high when user accesses are accepted.

Function
REQ-015 Access acceptance: an access SHALL be accepted on an edge where en=1 and ready_o=1; inputs are ignored when ready_o=0.
REQ-016 Read (we all zero): the word at addr SHALL appear on data_o 1+DO_REG cycles after the accepting edge, with valid_o=1 in that cycle only.
REQ-017 Byte write: only the bytes whose we bit is 1 SHALL be updated at the accepting edge; the other bytes keep their old value.
REQ-018 WRITE_MODE=0 (NO_CHANGE): on a write, data_o SHALL hold its previous value and valid_o SHALL stay 0.
REQ-019 WRITE_MODE=1 (READ_FIRST): on a write, data_o SHALL present the pre-write word, with valid_o pulsed and read latency.
REQ-020 WRITE_MODE=2 (WRITE_FIRST): on a write, data_o SHALL present the merged post-write word, with valid_o pulsed and read latency.
REQ-021 Back-to-back: one access per cycle SHALL be sustained; there are no bubbles and the pipeline holds no per-access state other than the output stage(s).
REQ-022 The FSM SHALL have states CLEAR and READY; ready_o=1 exactly in READY.
REQ-023 CLEAR state: the block SHALL write zero to the address given by the clear counter each cycle, counting 0 to depth-1, and move to READY on the cycle after writing depth-1.
REQ-024 Clear duration: the clear SHALL take exactly 2**ADDRESS_WIDTH cycles after reset deassertion, and the counter SHALL not wrap.
REQ-025 CLEAR_ON_RESET=0: the FSM SHALL enter READY directly from reset, and memory contents are undefined until written.
REQ-026 Clear writes SHALL never pulse valid_o or change data_o.
REQ-027 An in-flight read whose pipeline spans an entry into CLEAR cannot occur; only reset enters CLEAR, and reset flushes the pipeline.
REQ-028 Address wrap: addresses SHALL use modulo 2**ADDRESS_WIDTH decoding, with no out-of-range check.

Reset
REQ-029 While rst=1, the block SHALL force data_o=0, valid_o=0, ready_o=0, clear counter=0 and all output pipeline registers=0, asynchronously.
REQ-030 After rst falls, the FSM SHALL be in CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0) at the first clock edge.
REQ-031 Reset asserted mid-clear or mid-read SHALL abort the operation; the clear restarts from address 0 after release.
REQ-032 rst SHALL not reset memory contents directly.

Verification
REQ-033 ADDRESS_WIDTH=4, CLEAR_ON_RESET=1: release rst -> ready_o rises exactly 16 cycles later; reads of all 16 addresses return 0.
REQ-034 DO_REG=0 then 1: write 0x1234 at addr 3, then read addr 3 -> data_o=0x1234 with valid_o pulse 1 and 2 cycles after the read edge respectively.
REQ-035 Byte enable: word 0xAAAA at addr 5, write di=0x5555 with we=2'b01 -> read returns 0xAA55.
REQ-036 Write modes: old 0x0001, write 0x0002 at the same addr -> mode 0: data_o unchanged, no valid; mode 1: 0x0001 with valid; mode 2: 0x0002 with valid.
REQ-037 Clear abort: assert rst at clear address 7, release -> counter restarts at 0, full 16 cycles elapse before ready_o; en=1 during CLEAR -> no valid_o and no memory change.
REQ-038 Streaming: 16 consecutive reads, addr 0..15, one per cycle -> 16 consecutive valid_o pulses with data in address order.
